// File: rtl/integ_dump.sv
// Integrate-and-dump accumulator with valid-qualified input, runtime window
// length, saturating or wrapping arithmetic and a sticky overflow flag.
module integ_dump #(
  parameter int W_IN  = 10,
  parameter int W_ACC = 16,
  parameter int LW    = 8,
  parameter int SAT   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic [LW-1:0]           len,
  input  logic signed [W_IN-1:0]  din,
  input  logic                    din_vld,
  output logic signed [W_ACC-1:0] dout,
  output logic                    dout_vld,
  output logic                    ovf
);

  localparam logic [W_ACC-1:0] ACC_MAX = {1'b0, {(W_ACC-1){1'b1}}};
  localparam logic [W_ACC-1:0] ACC_MIN = {1'b1, {(W_ACC-1){1'b0}}};
  localparam logic [LW-1:0]    CNT_ONE = {{(LW-1){1'b0}}, 1'b1};

  // Reduce the one-bit-wider sum to W_ACC bits; the clamp sign comes from the sum MSB.
  function automatic logic [W_ACC-1:0] fold(input logic [W_ACC:0] s);
    logic [W_ACC-1:0] r;
    if ((SAT != 0) && (s[W_ACC] != s[W_ACC-1])) begin
      r = s[W_ACC] ? ACC_MIN : ACC_MAX;
    end else begin
      r = s[W_ACC-1:0];
    end
    return r;
  endfunction

  logic [W_ACC-1:0] acc_r, acc_nxt_s;
  logic [LW-1:0]    cnt_r, cnt_nxt_s;
  logic [LW-1:0]    len_q_r, len_nxt_s;
  logic [W_ACC-1:0] dout_r, dout_nxt_s;
  logic             vld_r, vld_nxt_s;
  logic             ovf_r, ovf_nxt_s;
  logic [W_ACC:0]   sum_s;
  logic             ovf_s;
  logic [W_ACC-1:0] res_s;

  assign sum_s = {acc_r[W_ACC-1], acc_r} + {{(W_ACC+1-W_IN){din[W_IN-1]}}, din};
  assign ovf_s = sum_s[W_ACC] ^ sum_s[W_ACC-1];
  assign res_s = fold(sum_s);

  // Next-state selection for the window: clear, hold, accumulate or dump.
  always_comb begin
    acc_nxt_s  = acc_r;
    cnt_nxt_s  = cnt_r;
    len_nxt_s  = len_q_r;
    dout_nxt_s = dout_r;
    vld_nxt_s  = 1'b0;
    ovf_nxt_s  = ovf_r;
    if (clr) begin
      acc_nxt_s  = {W_ACC{1'b0}};
      cnt_nxt_s  = {LW{1'b0}};
      len_nxt_s  = len;
      dout_nxt_s = {W_ACC{1'b0}};
      ovf_nxt_s  = 1'b0;
    end else if (din_vld) begin
      ovf_nxt_s = ovf_r | ovf_s;
      if (len_q_r == {LW{1'b0}}) begin
        acc_nxt_s  = res_s;
        dout_nxt_s = res_s;
        vld_nxt_s  = 1'b1;
        len_nxt_s  = len;
      end else if (cnt_r == (len_q_r - CNT_ONE)) begin
        acc_nxt_s  = {W_ACC{1'b0}};
        cnt_nxt_s  = {LW{1'b0}};
        dout_nxt_s = res_s;
        vld_nxt_s  = 1'b1;
        len_nxt_s  = len;
      end else begin
        acc_nxt_s = res_s;
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end else begin
      vld_nxt_s = 1'b0;
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r   <= {W_ACC{1'b0}};
      cnt_r   <= {LW{1'b0}};
      len_q_r <= len;
      dout_r  <= {W_ACC{1'b0}};
      vld_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      acc_r   <= acc_nxt_s;
      cnt_r   <= cnt_nxt_s;
      len_q_r <= len_nxt_s;
      dout_r  <= dout_nxt_s;
      vld_r   <= vld_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  assign dout     = dout_r;
  assign dout_vld = vld_r;
  assign ovf      = ovf_r;

endmodule

// File: tb/tb_integ_dump.sv
// Bench for integ_dump: a saturating and a wrapping instance share stimulus
// and are compared every cycle against an integer-arithmetic window model.
module tb_integ_dump;

  localparam int MAXV = 32767;
  localparam int MINV = -32768;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clr = 1'b0;
  logic [7:0]        len = 8'd0;
  logic signed [9:0] din = 10'sd0;
  logic              din_vld = 1'b0;
  logic signed [15:0] dout_sat, dout_wrap;
  logic              vld_sat, vld_wrap, ovf_sat, ovf_wrap;

  int n_vec = 0;
  int n_err = 0;

  // model state; index 0 = saturating instance, 1 = wrapping instance
  int m_acc [2];
  int m_dout[2];
  int m_ovf [2];
  int m_vld;
  int m_cnt;
  int m_len;
  int win_sum;

  always #5 clk = ~clk;

  integ_dump #(.W_IN(10), .W_ACC(16), .LW(8), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .len(len), .din(din), .din_vld(din_vld),
    .dout(dout_sat), .dout_vld(vld_sat), .ovf(ovf_sat)
  );

  integ_dump #(.W_IN(10), .W_ACC(16), .LW(8), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .len(len), .din(din), .din_vld(din_vld),
    .dout(dout_wrap), .dout_vld(vld_wrap), .ovf(ovf_wrap)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int fit(input int s, input bit sat);
    if (s >= MINV && s <= MAXV) return s;
    if (sat) return (s > MAXV) ? MAXV : MINV;
    return ((((s - MINV) % 65536) + 65536) % 65536) + MINV;
  endfunction

  task automatic model(input bit r, input bit c, input bit v, input int l, input int d);
    int res[2];
    if (r || c) begin
      for (int i = 0; i < 2; i++) begin
        m_acc[i] = 0; m_dout[i] = 0; m_ovf[i] = 0;
      end
      m_vld = 0; m_cnt = 0; m_len = l;
    end else if (!v) begin
      m_vld = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        int s;
        s = m_acc[i] + d;
        if (s > MAXV || s < MINV) m_ovf[i] = 1;
        res[i] = fit(s, i == 0);
      end
      if (m_len == 0) begin
        for (int i = 0; i < 2; i++) begin m_acc[i] = res[i]; m_dout[i] = res[i]; end
        m_vld = 1; m_len = l;
      end else if (m_cnt == m_len - 1) begin
        for (int i = 0; i < 2; i++) begin m_acc[i] = 0; m_dout[i] = res[i]; end
        m_vld = 1; m_cnt = 0; m_len = l;
      end else begin
        for (int i = 0; i < 2; i++) m_acc[i] = res[i];
        m_vld = 0; m_cnt++;
      end
    end
  endtask

  task automatic step(input bit r, input bit c, input bit v, input int l, input int d);
    @(negedge clk);
    rst = r; clr = c; din_vld = v; len = 8'(l); din = 10'(d);
    @(posedge clk);
    model(r, c, v, l, d);
    #1;
    chk("dout_sat",  int'(dout_sat),  m_dout[0]);
    chk("vld_sat",   int'(vld_sat),   m_vld);
    chk("ovf_sat",   int'(ovf_sat),   m_ovf[0]);
    chk("dout_wrap", int'(dout_wrap), m_dout[1]);
    chk("vld_wrap",  int'(vld_wrap),  m_vld);
    chk("ovf_wrap",  int'(ovf_wrap),  m_ovf[1]);
  endtask

  initial begin
    // reset state
    step(1'b1, 1'b0, 1'b0, 4, 0);
    chk("rst_dout", int'(dout_sat), 0);
    chk("rst_vld", int'(vld_sat), 0);

    // len=4 back-to-back windows
    for (int k = 1; k <= 4; k++) step(1'b0, 1'b0, 1'b1, 4, k);
    chk("win1_10", int'(dout_sat), 10);
    chk("win1_vld", int'(vld_sat), 1);
    for (int k = 5; k <= 8; k++) step(1'b0, 1'b0, 1'b1, 4, k);
    chk("win2_26", int'(dout_sat), 26);
    chk("win_ovf", int'(ovf_sat), 0);

    // same data, din_vld low on alternate cycles
    step(1'b1, 1'b0, 1'b0, 4, 0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0, 1'b1, 4, k);
      if (k == 4) chk("gap_10", int'(dout_sat), 10);
      if (k == 8) chk("gap_26", int'(dout_sat), 26);
      step(1'b0, 1'b0, 1'b0, 4, int'($urandom_range(0, 1023)) - 512);
      chk("gap_vld_low", int'(vld_sat), 0);
    end
    chk("gap_hold_26", int'(dout_sat), 26);

    // free-running, positive overflow in both modes
    step(1'b1, 1'b0, 1'b0, 0, 0);
    for (int k = 1; k <= 70; k++) begin
      step(1'b0, 1'b0, 1'b1, 0, 511);
      if (k == 64) chk("fr64_ovf", int'(ovf_sat), 0);
      if (k == 65) begin
        chk("fr65_sat", int'(dout_sat), 32767);
        chk("fr65_wrap", int'(dout_wrap), -32321);
        chk("fr65_ovf", int'(ovf_wrap), 1);
      end
    end
    chk("fr70_sat", int'(dout_sat), 32767);

    // free-running, negative boundary
    step(1'b1, 1'b0, 1'b0, 0, 0);
    for (int k = 1; k <= 65; k++) begin
      step(1'b0, 1'b0, 1'b1, 0, -512);
      if (k == 64) begin
        chk("neg64_dout", int'(dout_sat), -32768);
        chk("neg64_ovf", int'(ovf_sat), 0);
      end
    end
    chk("neg65_dout", int'(dout_sat), -32768);
    chk("neg65_ovf", int'(ovf_sat), 1);

    // clear mid-window drops the coincident sample
    step(1'b1, 1'b0, 1'b0, 4, 0);
    step(1'b0, 1'b0, 1'b1, 4, 3);
    step(1'b0, 1'b0, 1'b1, 4, 3);
    step(1'b0, 1'b1, 1'b1, 4, 100);
    chk("clr_no_vld", int'(vld_sat), 0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 4, 1);
    chk("clr_dout4", int'(dout_sat), 4);
    chk("clr_ovf", int'(ovf_sat), 0);

    // len change mid-window applies to the next window
    step(1'b1, 1'b0, 1'b0, 4, 0);
    step(1'b0, 1'b0, 1'b1, 4, 2);
    step(1'b0, 1'b0, 1'b1, 4, 2);
    step(1'b0, 1'b0, 1'b1, 2, 2);
    chk("len_chg_nodump", int'(vld_sat), 0);
    step(1'b0, 1'b0, 1'b1, 2, 2);
    chk("len_chg_dump8", int'(dout_sat), 8);
    step(1'b0, 1'b0, 1'b1, 2, 7);
    step(1'b0, 1'b0, 1'b1, 2, 5);
    chk("len2_dump12", int'(dout_sat), 12);

    // mid-window reset restarts with the new len
    step(1'b0, 1'b0, 1'b1, 2, 9);
    step(1'b1, 1'b0, 1'b1, 3, 9);
    chk("rst_mid_dout", int'(dout_sat), 0);
    chk("rst_mid_vld", int'(vld_sat), 0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 3, 10);
    chk("rst_mid_len3", int'(dout_sat), 30);

    // len=1: every valid sample dumps
    step(1'b1, 1'b0, 1'b0, 1, 0);
    step(1'b0, 1'b0, 1'b1, 1, -77);
    chk("len1_dout", int'(dout_sat), -77);

    // randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      bit r, c, v;
      int l, d;
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      d = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 511 : -512)
                                      : int'($urandom_range(0, 1023)) - 512;
      step(r, c, v, l, d);
    end
    win_sum = m_cnt;
    chk("cnt_range", int'(win_sum < 8), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
